// File: rtl/fib_pkg.sv
// Shared types and width helpers for the FIB longest-prefix-match pipeline.
package fib_pkg;

  localparam int FIB_TREE_HEIGHT     = 3;
  localparam int FIB_WORD_SIZE       = 32;
  localparam int FIB_MAX_NAME_LENGTH = 8;
  localparam int FIB_POINTER_SIZE    = 16;
  localparam int FIB_LEVEL_ADDR_W    = 8;
  localparam int FIB_FACE_W          = 8;
  localparam int FIB_TAG_W           = 8;

  // Width of a component count that must also represent the full length.
  function automatic int lenWidth(input int maxNameLength);
    return $clog2(maxNameLength + 1);
  endfunction

  // Width of a selector among count items, never narrower than one bit.
  function automatic int selWidth(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  localparam int FIB_LEN_W = lenWidth(FIB_MAX_NAME_LENGTH);

  // One trie node as written by the control plane.
  typedef struct packed {
    logic                        valid;
    logic [FIB_WORD_SIZE-1:0]    key;
    logic [FIB_POINTER_SIZE-1:0] childBase;
    logic                        hasChild;
    logic                        isPrefix;
    logic [FIB_FACE_W-1:0]       face;
  } node_t;

  // Per-request state carried from level to level.
  typedef struct packed {
    logic                                             valid;
    logic [FIB_MAX_NAME_LENGTH-1:0][FIB_WORD_SIZE-1:0] name;
    logic [FIB_LEN_W-1:0]                             len;
    logic [FIB_LEN_W-1:0]                             idx;
    logic [FIB_POINTER_SIZE-1:0]                      ptr;
    logic                                             done;
    logic                                             hit;
    logic [FIB_FACE_W-1:0]                            face;
    logic [FIB_LEN_W-1:0]                             depth;
    logic [FIB_TAG_W-1:0]                             tag;
  } ctx_t;

endpackage

// File: rtl/fib_lookup_pipeline_stage.sv
// One trie level: node memory, address register and compare/update register.
module fib_level_stage
  import fib_pkg::*;
#(
  parameter int LEVEL_ID        = 0,
  parameter int MAX_NAME_LENGTH = FIB_MAX_NAME_LENGTH,
  parameter int LEVEL_ADDR_W    = FIB_LEVEL_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  ctx_t                    ctxIn,
  output ctx_t                    ctxOut,
  input  logic                    wrEn,
  input  logic [LEVEL_ADDR_W-1:0] wrAddr,
  input  node_t                   wrNode
);

  localparam int DEPTH = 1 << LEVEL_ADDR_W;
  // A context still walking at this level has consumed exactly LEVEL_ID
  // components, so its current component is a fixed slot rather than a mux
  // on idx. Levels beyond the name length can never be reached undone.
  localparam int COMP_SEL = (LEVEL_ID < MAX_NAME_LENGTH) ? LEVEL_ID : MAX_NAME_LENGTH - 1;

  logic                    vld_p0;
  logic                    rdEn_p0;
  ctx_t                    ctx_p0;
  logic [LEVEL_ADDR_W-1:0] addr_p0;
  logic                    vld_p1;
  ctx_t                    ctx_p1;

  logic [DEPTH-1:0]        nodeValid;
  node_t                   nodeMem [DEPTH];
  node_t                   rdNode;
  ctx_t                    ctxNext;
  logic [LEVEL_ADDR_W-1:0] rdAddr;
  logic [FIB_LEN_W-1:0]    nextIdx;

  assign rdAddr = ctxIn.ptr[LEVEL_ADDR_W-1:0] + ctxIn.name[COMP_SEL][LEVEL_ADDR_W-1:0];

  // Address stage control: valid and read enable (done contexts skip the read)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      rdEn_p0 <= 1'b0;
    end else begin
      vld_p0  <= ctxIn.valid;
      rdEn_p0 <= ctxIn.valid && !ctxIn.done;
    end
  end

  // Address stage data: context and node address
  always_ff @(posedge clk) begin
    ctx_p0  <= ctxIn;
    addr_p0 <= rdAddr;
  end

  // Entry valid bits are cleared by reset so an empty table misses everywhere
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nodeValid <= '0;
    end else if (wrEn) begin
      nodeValid[wrAddr] <= wrNode.valid;
    end
  end

  // Entry payload storage, written from the control plane, never reset
  always_ff @(posedge clk) begin
    if (wrEn) begin
      nodeMem[wrAddr] <= wrNode;
    end
  end

  // Asynchronous read: a same-cycle write lands at the edge, so the read sees the old entry
  always_comb begin
    rdNode       = nodeMem[addr_p0];
    rdNode.valid = nodeValid[addr_p0];
  end

  // Match and context update for a context still walking the trie
  always_comb begin
    ctxNext = ctx_p0;
    nextIdx = ctx_p0.idx + FIB_LEN_W'(1);
    if (rdEn_p0) begin
      if (rdNode.valid && (rdNode.key == ctx_p0.name[COMP_SEL])) begin
        ctxNext.idx = nextIdx;
        if (rdNode.isPrefix) begin
          ctxNext.hit   = 1'b1;
          ctxNext.face  = rdNode.face;
          ctxNext.depth = nextIdx;
        end
        ctxNext.ptr  = rdNode.childBase;
        ctxNext.done = !rdNode.hasChild || (nextIdx == ctx_p0.len);
      end else begin
        ctxNext.done = 1'b1;
      end
    end
  end

  // Compare stage control: valid follows the address stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
    end
  end

  // Compare stage data: updated context
  always_ff @(posedge clk) begin
    ctx_p1 <= ctxNext;
  end

  // Present the context with its reset-controlled valid
  always_comb begin
    ctxOut       = ctx_p1;
    ctxOut.valid = vld_p1;
  end

endmodule

// File: rtl/fib_lookup_pipeline.sv
// Fully pipelined longest-prefix-match over a TREE_HEIGHT-level name trie.
module fib_lookup_pipeline
  import fib_pkg::*;
#(
  parameter int TREE_HEIGHT     = FIB_TREE_HEIGHT,
  parameter int WORD_SIZE       = FIB_WORD_SIZE,
  parameter int MAX_NAME_LENGTH = FIB_MAX_NAME_LENGTH,
  parameter int POINTER_SIZE    = FIB_POINTER_SIZE,
  parameter int LEVEL_ADDR_W    = FIB_LEVEL_ADDR_W,
  parameter int FACE_W          = FIB_FACE_W,
  parameter int TAG_W           = FIB_TAG_W,
  localparam int LEN_W          = lenWidth(MAX_NAME_LENGTH),
  localparam int LVL_W          = selWidth(TREE_HEIGHT)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  input  logic [MAX_NAME_LENGTH-1:0][WORD_SIZE-1:0] in_name,
  input  logic [LEN_W-1:0]                        in_len,
  input  logic [TAG_W-1:0]                        in_tag,
  input  logic                                    wr_en,
  input  logic [LVL_W-1:0]                        wr_level,
  input  logic [LEVEL_ADDR_W-1:0]                 wr_addr,
  input  node_t                                   wr_node,
  output logic                                    out_valid,
  output logic [TAG_W-1:0]                        out_tag,
  output logic                                    out_hit,
  output logic [FACE_W-1:0]                       out_face,
  output logic [LEN_W-1:0]                        out_depth
);

  ctx_t             ctxIn0;
  logic [LEN_W-1:0] lenClamped;
  ctx_t             stageOut [TREE_HEIGHT];
  ctx_t             lastCtx;
  logic             unusedCtxBits;

  // Stage-0 context: clamp the length, start at the root with nothing matched
  always_comb begin
    lenClamped   = (in_len > LEN_W'(MAX_NAME_LENGTH)) ? LEN_W'(MAX_NAME_LENGTH) : in_len;
    ctxIn0       = '0;
    ctxIn0.valid = in_valid;
    ctxIn0.name  = in_name;
    ctxIn0.len   = lenClamped;
    ctxIn0.idx   = '0;
    ctxIn0.ptr   = {POINTER_SIZE{1'b0}};
    ctxIn0.done  = (lenClamped == '0);
    ctxIn0.hit   = 1'b0;
    ctxIn0.face  = '0;
    ctxIn0.depth = '0;
    ctxIn0.tag   = in_tag;
  end

  for (genvar s = 0; s < TREE_HEIGHT; s++) begin : g_level
    ctx_t stageIn;
    logic levelWrEn;

    if (s == 0) begin : g_first
      assign stageIn = ctxIn0;
    end else begin : g_chain
      assign stageIn = stageOut[s-1];
    end

    assign levelWrEn = wr_en && (wr_level == LVL_W'(s));

    fib_level_stage #(
      .LEVEL_ID       (s),
      .MAX_NAME_LENGTH(MAX_NAME_LENGTH),
      .LEVEL_ADDR_W   (LEVEL_ADDR_W)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .ctxIn (stageIn),
      .ctxOut(stageOut[s]),
      .wrEn  (levelWrEn),
      .wrAddr(wr_addr),
      .wrNode(wr_node)
    );
  end

  assign lastCtx = stageOut[TREE_HEIGHT-1];
  // Walk state that the result does not need
  assign unusedCtxBits = ^{lastCtx.name, lastCtx.len, lastCtx.idx, lastCtx.ptr, lastCtx.done};

  // Result register: result fields load only with a valid context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_hit   <= 1'b0;
      out_face  <= '0;
      out_depth <= '0;
    end else begin
      out_valid <= lastCtx.valid;
      if (lastCtx.valid) begin
        out_tag   <= lastCtx.tag;
        out_hit   <= lastCtx.hit;
        out_face  <= lastCtx.face;
        out_depth <= lastCtx.depth;
      end
    end
  end

endmodule

// File: tb/tb_fib_lookup_pipeline.sv
// Self-checking bench for fib_lookup_pipeline with a behavioural trie model.
`timescale 1ns/1ps
module tb_fib_lookup_pipeline;
  import fib_pkg::*;

  localparam int TH      = 3;
  localparam int WS      = 32;
  localparam int ML      = 8;
  localparam int PS      = 16;
  localparam int AW      = 8;
  localparam int FW      = 8;
  localparam int TW      = 8;
  localparam int LEN_W   = 4;
  localparam int LVL_W   = 2;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 2 * TH + 1;

  typedef logic [ML-1:0][WS-1:0] name_t;

  typedef struct {
    int               due;
    logic [TW-1:0]    tag;
    logic             hit;
    logic [FW-1:0]    face;
    logic [LEN_W-1:0] depth;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  name_t            in_name = '0;
  logic [LEN_W-1:0] in_len = '0;
  logic [TW-1:0]    in_tag = '0;
  logic             wr_en = 1'b0;
  logic [LVL_W-1:0] wr_level = '0;
  logic [AW-1:0]    wr_addr = '0;
  node_t            wr_node = '0;
  logic             out_valid;
  logic [TW-1:0]    out_tag;
  logic             out_hit;
  logic [FW-1:0]    out_face;
  logic [LEN_W-1:0] out_depth;

  exp_t  sb[$];
  node_t refNode  [TH][DEPTH];
  bit    refValid [TH][DEPTH];
  int    cyc    = 0;
  int    nTests = 0;
  int    nFail  = 0;

  always #5 clk = ~clk;

  fib_lookup_pipeline dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_name  (in_name),
    .in_len   (in_len),
    .in_tag   (in_tag),
    .wr_en    (wr_en),
    .wr_level (wr_level),
    .wr_addr  (wr_addr),
    .wr_node  (wr_node),
    .out_valid(out_valid),
    .out_tag  (out_tag),
    .out_hit  (out_hit),
    .out_face (out_face),
    .out_depth(out_depth)
  );

  // Longest-prefix match over the model table: one level per component.
  function automatic void refLookup(input name_t name, input int len, output logic hit,
                                    output logic [FW-1:0] face, output logic [LEN_W-1:0] depth);
    int n;
    int base;
    int a;
    n     = (len > ML) ? ML : len;
    base  = 0;
    hit   = 1'b0;
    face  = '0;
    depth = '0;
    for (int lvl = 0; lvl < TH && lvl < n; lvl++) begin
      a = (base + int'(name[lvl][AW-1:0])) % DEPTH;
      if (!refValid[lvl][a] || refNode[lvl][a].key != name[lvl]) break;
      if (refNode[lvl][a].isPrefix) begin
        hit   = 1'b1;
        face  = refNode[lvl][a].face;
        depth = LEN_W'(lvl + 1);
      end
      if (!refNode[lvl][a].hasChild) break;
      base = int'(refNode[lvl][a].childBase);
    end
  endfunction

  function automatic node_t mkNode(input logic v, input logic [WS-1:0] key, input logic [PS-1:0] cb,
                                   input logic hc, input logic ip, input logic [FW-1:0] face);
    node_t n;
    n.valid     = v;
    n.key       = key;
    n.childBase = cb;
    n.hasChild  = hc;
    n.isPrefix  = ip;
    n.face      = face;
    return n;
  endfunction

  function automatic name_t mkName(input logic [WS-1:0] c0, input logic [WS-1:0] c1, input logic [WS-1:0] c2);
    name_t n;
    n    = '0;
    n[0] = c0;
    n[1] = c1;
    n[2] = c2;
    return n;
  endfunction

  function automatic name_t randName();
    name_t n;
    n = '0;
    for (int i = 0; i < ML; i++) begin
      n[i] = WS'($urandom_range(1, 5));
      if ($urandom_range(0, 9) == 0) n[i] = n[i] | 32'h100;
    end
    return n;
  endfunction

  task automatic chk(input string what, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", what, obs, exp, cyc);
    end
  endtask

  task automatic checkOutputs();
    exp_t e;
    if (sb.size() != 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("out_valid", 64'(out_valid), 64'(1));
      chk("out_tag",   64'(out_tag),   64'(e.tag));
      chk("out_hit",   64'(out_hit),   64'(e.hit));
      chk("out_face",  64'(out_face),  64'(e.face));
      chk("out_depth", 64'(out_depth), 64'(e.depth));
    end else begin
      chk("out_valid_idle", 64'(out_valid), 64'(0));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    in_valid = 1'b0;
    wr_en    = 1'b0;
    checkOutputs();
  endtask

  task automatic issueExp(input name_t name, input int len, input logic [TW-1:0] tag,
                          input logic hit, input logic [FW-1:0] face, input logic [LEN_W-1:0] depth);
    exp_t e;
    in_valid = 1'b1;
    in_name  = name;
    in_len   = LEN_W'(len);
    in_tag   = tag;
    e.due    = cyc + LATENCY;
    e.tag    = tag;
    e.hit    = hit;
    e.face   = face;
    e.depth  = depth;
    sb.push_back(e);
  endtask

  task automatic issue(input name_t name, input int len, input logic [TW-1:0] tag);
    logic             h;
    logic [FW-1:0]    f;
    logic [LEN_W-1:0] d;
    refLookup(name, len, h, f, d);
    issueExp(name, len, tag, h, f, d);
  endtask

  task automatic writeNode(input int level, input int addr, input node_t node);
    wr_en    = 1'b1;
    wr_level = LVL_W'(level);
    wr_addr  = AW'(addr);
    wr_node  = node;
    refNode[level][addr]  = node;
    refValid[level][addr] = node.valid;
  endtask

  task automatic checkResetOutputs(input string prefix);
    chk({prefix, "_valid"}, 64'(out_valid), 64'(0));
    chk({prefix, "_hit"},   64'(out_hit),   64'(0));
    chk({prefix, "_face"},  64'(out_face),  64'(0));
    chk({prefix, "_depth"}, 64'(out_depth), 64'(0));
    chk({prefix, "_tag"},   64'(out_tag),   64'(0));
  endtask

  initial begin
    // Power-on reset
    #2 rst_n = 1'b0;
    tick();
    tick();
    checkResetOutputs("reset");
    rst_n = 1'b1;
    tick();

    // Empty table misses
    issueExp(mkName(32'hA, 32'h0, 32'h0), 1, 8'd5, 1'b0, 8'd0, 4'd0);
    tick();
    repeat (LATENCY + 1) tick();

    // Two-level prefix table
    writeNode(0, 'h0A, mkNode(1'b1, 32'hA, 16'h10, 1'b1, 1'b1, 8'd3));
    tick();
    writeNode(1, 'h1B, mkNode(1'b1, 32'hB, 16'h00, 1'b0, 1'b1, 8'd7));
    tick();
    issueExp(mkName(32'hA, 32'hB, 32'h0), 2, 8'h11, 1'b1, 8'd7, 4'd2);
    tick();
    issueExp(mkName(32'hA, 32'hC, 32'h0), 2, 8'h12, 1'b1, 8'd3, 4'd1);
    tick();
    issueExp(mkName(32'hA, 32'hB, 32'h0), 0, 8'h13, 1'b0, 8'd0, 4'd0);
    tick();
    issueExp(mkName(32'hA, 32'hB, 32'h5), 12, 8'h14, 1'b1, 8'd7, 4'd2);
    tick();
    issueExp(mkName(32'h10A, 32'hB, 32'h0), 2, 8'h15, 1'b0, 8'd0, 4'd0);
    tick();
    repeat (LATENCY + 1) tick();

    // Write racing a read of the same entry
    issueExp(mkName(32'hA, 32'hB, 32'h0), 2, 8'h20, 1'b1, 8'd7, 4'd2);
    tick();
    writeNode(0, 'h0A, mkNode(1'b1, 32'hA, 16'h10, 1'b0, 1'b1, 8'd9));
    issueExp(mkName(32'hA, 32'hB, 32'h0), 2, 8'h21, 1'b1, 8'd9, 4'd1);
    tick();
    repeat (LATENCY + 1) tick();

    // Random three-level table
    for (int lvl = 0; lvl < TH; lvl++) begin
      for (int b = 0; b < 4; b++) begin
        for (int k = 1; k <= 4; k++) begin
          writeNode(lvl, b * 16 + k,
                    mkNode(1'($urandom_range(0, 9) != 0), WS'(k), PS'($urandom_range(0, 3) * 16),
                           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                           FW'($urandom_range(1, 255))));
          tick();
        end
      end
    end

    // Back-to-back lookups, tags 0..9
    for (int t = 0; t < 10; t++) begin
      issue(randName(), int'($urandom_range(1, ML)), TW'(t));
      tick();
    end

    // Random lookups with gaps, including zero and over-long lengths
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0) issue(randName(), int'($urandom_range(0, ML + 2)), TW'(8'h40 + i));
      tick();
    end
    repeat (LATENCY + 1) tick();

    // Reset with lookups in flight
    writeNode(0, 'h0A, mkNode(1'b1, 32'hA, 16'h10, 1'b1, 1'b1, 8'd3));
    tick();
    for (int t = 0; t < 4; t++) begin
      issue(mkName(32'hA, 32'hB, 32'h0), 2, TW'(8'h80 + t));
      tick();
    end
    rst_n = 1'b0;
    sb.delete();
    for (int lvl = 0; lvl < TH; lvl++) begin
      for (int a = 0; a < DEPTH; a++) refValid[lvl][a] = 1'b0;
    end
    #1;
    checkResetOutputs("midreset");
    tick();
    rst_n = 1'b1;
    repeat (LATENCY + 2) tick();
    issueExp(mkName(32'hA, 32'hB, 32'h0), 2, 8'h90, 1'b0, 8'd0, 4'd0);
    tick();
    repeat (LATENCY + 1) tick();

    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/fib_lookup_pipeline.md
# fib_lookup_pipeline

Parametrised, fully pipelined longest-prefix-match engine for NDN names. One lookup is accepted per clock. Each lookup walks a TREE_HEIGHT-level name trie, one level per stage, consuming one name component per matched level. It returns the face of the longest matching prefix. It sits between the name parser, which supplies components, length and tag, and the forwarding stage, which consumes face and hit. It carries its own per-level node memories with a control-plane write port.

## Interface
- TREE_HEIGHT, 3, number of trie levels (pipeline stages)
- WORD_SIZE, 32, bits per name component
- MAX_NAME_LENGTH, 8, maximum components per name
- POINTER_SIZE, 16, width of child base pointer
- LEVEL_ADDR_W, 8, address width of each level memory (depth 2^LEVEL_ADDR_W)
- FACE_W, 8, face identifier width
- TAG_W, 8, opaque request tag width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  lookup request this cycle (always accepted)
- in_name  in  MAX_NAME_LENGTH×WORD_SIZE  name components, index 0 first
- in_len  in  $clog2(MAX_NAME_LENGTH+1)  component count
- in_tag  in  TAG_W  returned unchanged with result
- wr_en  in  1  node memory write
- wr_level  in  $clog2(TREE_HEIGHT)  target level
- wr_addr  in  LEVEL_ADDR_W  target entry
- wr_node  in  node_t  entry contents {valid, key, child_base, has_child, is_prefix, face}
- out_valid  out  1  result valid
- out_tag  out  TAG_W  tag of the completed lookup
- out_hit  out  1  at least one prefix matched
- out_face  out  FACE_W  face of the longest matched prefix (0 on miss)
- out_depth  out  $clog2(MAX_NAME_LENGTH+1)  components in the longest matched prefix

## Operation
- Per-request context is carried stage to stage: valid, name, len, idx, ptr, done, hit, face, depth, tag.
- Stage 0 entry values: ptr=0, idx=0, hit=0, face=0, depth=0, done=(in_len==0).
- Stage s, when !done:
  - Read address is (ptr + name[idx]) mod 2^LEVEL_ADDR_W, using the low LEVEL_ADDR_W bits of each operand.
  - match = node.valid && node.key==name[idx].
- On match:
  - idx += 1.
  - If is_prefix: hit=1, face=node.face, depth=idx+1.
  - ptr = child_base.
  - done = !has_child || idx+1==len.
- On mismatch: done=1.
- A done context passes through later stages unchanged. Those stages perform no memory read.
- The last stage output is registered onto out_*. out_valid mirrors the context valid.
- Writes use a separate port and take effect on the next clock.
- Read and write to the same level and address in the same cycle: the read returns the old entry.
- Per-entry valid bits are flops cleared by reset. Key, pointer, flag and face storage is not reset.

## Timing
- 2 cycles per stage: address register, then compare/update register.
- Latency from in_valid sampled to out_valid = 2·TREE_HEIGHT + 1 cycles. The default is 7.
- Throughput is 1 per cycle. There is no backpressure, and results leave in request order.
- Reset values:
  - out_valid=0, out_hit=0, out_face=0, out_depth=0, out_tag=0.
  - All stage context valid bits are 0.
  - All node valid bits are 0.
- Reset asserted mid-operation drops all in-flight lookups. No out_valid is produced for them.
- Names longer than TREE_HEIGHT stop matching after TREE_HEIGHT components. The result holds the best prefix found.
- If in_len > MAX_NAME_LENGTH, it is clamped to MAX_NAME_LENGTH.

## Structure
- fib_pkg holds:
  - node_t struct
  - ctx_t struct (pipeline context)
  - width constants derived from parameters via functions
- One sub-module, fib_level_stage: one level memory plus its two pipeline registers and match/update logic. It is instantiated TREE_HEIGHT times by generate, with LEVEL_ID as a parameter.
- The top holds the write-port decode (wr_level → per-stage write enable), the stage-0 context build and the output register.

## Test plan
- Empty table after reset. Lookup name {0xA}, len 1, tag 5 → 7 cycles later: out_valid=1, tag 5, hit=0, face 0, depth 0.
- Prefix hit:
  - Load level0 addr 0x0A {key 0xA, is_prefix, face 3, has_child, child_base 0x10} and level1 addr 0x1B {key 0xB, is_prefix, face 7}.
  - Lookup {0xA,0xB} → hit, face 7, depth 2.
  - Lookup {0xA,0xC} → hit, face 3, depth 1.
- Back-to-back: 10 consecutive lookups with tags 0..9 on consecutive cycles → 10 consecutive results in order. Each result's face matches the reference model.
- len=0 request → miss result at the fixed latency. Memories show no read activity.
- Write to level0 addr 0x0A in the same cycle the lookup reads it → the lookup sees the old entry. The next lookup sees the new entry.
- Assert rst_n for 1 cycle with 4 lookups in flight → no out_valid for them. A new lookup after reset misses because node valid bits were cleared.
